preg_freelist: RTL and testbench
================================

# preg_freelist

Physical-register free list for the 4-wide rename stage. Each cycle it hands out up to four free physical register numbers to the rename slots and drives the same numbers, packed, into the busy table's set-address port. Registers retired at commit are returned to the tail. A stall is raised when the list cannot cover a whole rename group.

## Interface
- `WIDTH`, 7, physical register address width (`2**WIDTH` physical registers).
- `ARCH`, 32, architectural registers; p0..p(ARCH-1) are mapped at reset and never start in the list.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset: one clock, synchronous, active-high.
- `i_valid`  in  1  rename group present this cycle.
- `i_req`  in  4  per-slot destination request; bit k = slot k writes a register other than x0.
- `o_ready`  out  1  free count ≥ popcount(`i_req`); combinational.
- `o_addr4x`  out  4*WIDTH  allocated register per slot, slot0 in the LSBs; 0 for non-requesting slots. Same packing as the busy table set port; 0 = no set.
- `i_free4x`  in  4*WIDTH  registers released at commit, slot0 in the LSBs; 0 = no release.
- `o_count`  out  WIDTH+1  current number of free entries.
- `o_empty`  out  1  `o_count == 0`.

## Operation
- Storage: circular buffer of `2**WIDTH` entries of WIDTH bits; `head` and `tail` are WIDTH bits and wrap modulo `2**WIDTH`; `count` is WIDTH+1 bits.
- Reset:
  - entry i = ARCH+i for i < `2**WIDTH`-ARCH;
  - head=0, tail=`2**WIDTH`-ARCH (96), count=96;
  - outputs: `o_count`=96, `o_empty`=0.
- Allocation fires when `i_valid && o_ready`. Requesting slots take entries head, head+1, … in slot order; non-requesting slots are skipped and output 0. head advances by popcount(`i_req`).
- `o_addr4x` is always driven from the head entries, whatever the value of `i_valid`. Outputs are forced to 0 for non-requesting slots, and for all slots when the allocation does not fire.
- `i_valid` with `o_ready`=0: nothing allocated, head unchanged, `o_addr4x`=0.
- Release: nonzero fields of `i_free4x` are compacted in slot order and written at tail, tail+1, …; tail advances by the number of nonzero fields.
- Simultaneous alloc and release: next count = count − nalloc + nfree. Released registers can be allocated from the cycle after release, never the same cycle.
- `i_req`=0 with `i_valid`=1 is legal. It fires, allocates nothing and `o_ready`=1.

## Timing
- Allocation is zero-latency. `o_addr4x` is valid in the same cycle as the request, and the busy table captures the set on the same `i_clk` edge that advances head.
- A release is visible in `o_count` one cycle after it is presented.
- Reset has priority over all other activity. A reset mid-group discards that group and the list returns to its reset contents.

## Configuration
- `FREELIST_ERR_EN` defined: adds output `o_err` (1 bit, reset 0), sticky until `i_rst`. It is set on either of these:
  - overflow: count + nfree > `2**WIDTH`-ARCH;
  - underflow: an allocation attempted past count, which is defence against an `o_ready` misuse.
  On error, the offending push or pop is still suppressed.
- Undefined: no `o_err` port. Overflow writes are dropped silently and count saturates at `2**WIDTH`-ARCH.

## Structure
- The shared package/header holds `PRF_W`=7, `ARCH_REGS`=32 and `RENAME_W`=4, common to rename, busy table and ROB.
- One sub-module, `freelist_compact`:
  - input: 4 WIDTH-bit fields plus a valid mask;
  - output: fields packed to the low slots, and the count of valid fields.
  - Instantiated for release compaction and reused for allocation slot-offset computation (prefix count of `i_req`).

## Test plan
- Reset, then `i_valid`=1, `i_req`=4'b1111 → `o_addr4x`={35,34,33,32}, `o_ready`=1; next cycle `o_count`=92.
- Next cycle `i_req`=4'b0101 → slot0=36, slot2=37, slots1,3=0; `o_count`=90.
- Drain to `o_count`=2, then `i_req`=4'b0111 → `o_ready`=0, `o_addr4x`=0, count stays 2. Then `i_req`=4'b0011 → allocates both; `o_empty`=1 next cycle.
- With count 10, `i_free4x`={0,0,50,40} and `i_req`=4'b0001 in the same cycle → slot0 gets the old head; next `o_count`=11; 40 and 50 are allocated later, in that order.
- Run 200 cycles of allocating 1 and freeing 1 → head and tail wrap past 127→0; the allocated sequence matches a FIFO model; count stays constant.
- With `FREELIST_ERR_EN`, from reset free 1 register → `o_err`=1 next cycle, `o_count` stays 96; `i_rst` clears `o_err`.

Source files
------------

// File: rtl/preg_freelist_pkg.sv
// Shared rename-stage constants: physical register width, architectural register count, rename width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Used by the rename free list, busy table and ROB so all three agree on widths.
package preg_freelist_pkg;

    localparam int PRF_W     = 7;   // physical register address width (2**PRF_W registers)
    localparam int ARCH_REGS = 32;  // p0..p31 hold the architectural state at reset
    localparam int RENAME_W  = 4;   // rename group width

    // Width of a slot index and of a "how many slots" count within one group.
    localparam int SLOT_W = $clog2(RENAME_W);
    localparam int CNT_W  = $clog2(RENAME_W + 1);

    typedef logic [CNT_W-1:0] slot_cnt_t;

endpackage

// File: rtl/preg_freelist_compact.sv
// Packs the masked-in fields of a rename group into the low slots and counts them.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   fields_i  RENAME_W fields of W bits, slot0 in the LSBs
//   mask_i    per-slot valid bit
//   packed_o  valid fields in slot order, packed to slot0 upward; unused slots are 0
//   count_o   number of valid fields
module freelist_compact
    import preg_freelist_pkg::*;
#(
    parameter int W = PRF_W
) (
    input  logic [RENAME_W*W-1:0] fields_i,
    input  logic [RENAME_W-1:0]   mask_i,
    output logic [RENAME_W*W-1:0] packed_o,
    output slot_cnt_t             count_o
);

    slot_cnt_t cnt;

    always_comb begin
        packed_o = '0;
        cnt      = '0;
        for (int k = 0; k < RENAME_W; k++) begin
            if (mask_i[k]) begin
                packed_o[cnt*W +: W] = fields_i[k*W +: W];
                cnt                  = cnt + CNT_W'(1);
            end
        end
        count_o = cnt;
    end

endmodule

// File: rtl/preg_freelist.sv
// Physical-register free list for the 4-wide rename stage: hands out up to four free registers
// per cycle and takes back registers released at commit.
// Latency: allocation is combinational (same cycle); a release is allocatable / counted the next cycle.
// Backpressure: o_ready drops when the free count cannot cover the whole group; nothing is allocated then.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid,i_req  rename group present, per-slot destination request
//   o_ready        free count >= popcount(i_req)
//   o_addr4x       allocated register per slot (0 = none), same packing as the busy-table set port
//   i_free4x       registers released at commit (0 = no release)
//   o_count        number of free entries, o_empty = (o_count == 0)
//   o_err          only when FREELIST_ERR_EN is defined: sticky overflow/underflow flag
module preg_freelist
    import preg_freelist_pkg::*;
#(
    parameter int WIDTH = PRF_W,
    parameter int ARCH  = ARCH_REGS
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [RENAME_W-1:0]       i_req,
    output logic                      o_ready,
    output logic [RENAME_W*WIDTH-1:0] o_addr4x,
    input  logic [RENAME_W*WIDTH-1:0] i_free4x,
    output logic [WIDTH:0]            o_count,
    output logic                      o_empty
`ifdef FREELIST_ERR_EN
    ,
    output logic                      o_err
`endif
);

    localparam int               DEPTH     = 2**WIDTH;
    localparam int               NFREE_RST = DEPTH - ARCH;
    // The list can never legitimately hold more than the non-architectural registers.
    localparam logic [WIDTH:0]   CAP       = (WIDTH+1)'(NFREE_RST);
    localparam logic [WIDTH-1:0] TAIL_RST  = WIDTH'(NFREE_RST);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [WIDTH:0]   count_q, count_d;

    // ------------------------------------------------------------------
    // Allocation ordering: compacting the slot indices under the request
    // mask gives, for the j-th allocation of the group, which slot it
    // belongs to. Allocation j reads entry head+j.
    // ------------------------------------------------------------------
    logic [RENAME_W*SLOT_W-1:0] slot_idx;
    logic [RENAME_W*SLOT_W-1:0] req_order;
    slot_cnt_t                  nreq;

    always_comb begin
        slot_idx = '0;
        for (int k = 0; k < RENAME_W; k++) begin
            slot_idx[k*SLOT_W +: SLOT_W] = SLOT_W'(k);
        end
    end

    freelist_compact #(
        .W (SLOT_W)
    ) u_alloc_order (
        .fields_i (slot_idx),
        .mask_i   (i_req),
        .packed_o (req_order),
        .count_o  (nreq)
    );

    // ------------------------------------------------------------------
    // Release compaction: nonzero fields packed in slot order.
    // ------------------------------------------------------------------
    logic [RENAME_W-1:0]       free_nz;
    logic [RENAME_W*WIDTH-1:0] free_packed;
    slot_cnt_t                 nfree;

    always_comb begin
        free_nz = '0;
        for (int k = 0; k < RENAME_W; k++) begin
            free_nz[k] = |i_free4x[k*WIDTH +: WIDTH];
        end
    end

    freelist_compact #(
        .W (WIDTH)
    ) u_release (
        .fields_i (i_free4x),
        .mask_i   (free_nz),
        .packed_o (free_packed),
        .count_o  (nfree)
    );

    // ------------------------------------------------------------------
    // Handshake and counts
    // ------------------------------------------------------------------
    logic           fire;
    slot_cnt_t      nalloc;
    slot_cnt_t      npush;
    logic [WIDTH:0] room;

    assign o_ready = (count_q >= (WIDTH+1)'(nreq));
    assign fire    = i_valid & o_ready;
    assign nalloc  = fire ? nreq : '0;

    // Room is measured against the count at the start of the cycle, so a
    // same-cycle allocation never makes space for a release. Fields beyond
    // the room are dropped and the count saturates at CAP.
    assign room  = CAP - count_q;
    assign npush = ((WIDTH+1)'(nfree) > room) ? room[CNT_W-1:0] : nfree;

    assign head_d  = head_q + WIDTH'(nalloc);
    assign tail_d  = tail_q + WIDTH'(npush);
    assign count_d = count_q - (WIDTH+1)'(nalloc) + (WIDTH+1)'(npush);

    assign o_count = count_q;
    assign o_empty = (count_q == '0);

    // Registers are read from the head entries combinationally; slots that
    // do not allocate (or a group that does not fire) output 0 so the busy
    // table sees "no set".
    always_comb begin
        o_addr4x = '0;
        if (fire) begin
            for (int j = 0; j < RENAME_W; j++) begin
                if (CNT_W'(j) < nreq) begin
                    o_addr4x[req_order[j*SLOT_W +: SLOT_W]*WIDTH +: WIDTH] = mem_q[head_q + WIDTH'(j)];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State. Written entries land at tail..tail+npush-1 and only become
    // visible to allocation through count_q on the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= TAIL_RST;
            count_q <= CAP;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < NFREE_RST) ? WIDTH'(ARCH + i) : '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int j = 0; j < RENAME_W; j++) begin
                if (CNT_W'(j) < npush) begin
                    mem_q[tail_q + WIDTH'(j)] <= free_packed[j*WIDTH +: WIDTH];
                end
            end
        end
    end

`ifdef FREELIST_ERR_EN
    // Overflow: a release that would exceed CAP. Underflow: a group offered
    // while o_ready is low. The offending excess is still suppressed above.
    logic err_q, err_d;
    logic overflow, underflow;

    assign overflow  = ((count_q + (WIDTH+1)'(nfree)) > CAP);
    assign underflow = i_valid & ~o_ready;
    assign err_d     = err_q | overflow | underflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_preg_freelist.sv
module tb_preg_freelist;
    import preg_freelist_pkg::*;

    localparam int W  = PRF_W;
    localparam int NR = 2**W - ARCH_REGS;  // free registers at reset (96)

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_valid = 1'b0;
    logic [3:0]         i_req = '0;
    logic               o_ready;
    logic [4*W-1:0]     o_addr4x;
    logic [4*W-1:0]     i_free4x = '0;
    logic [W:0]         o_count;
    logic               o_empty;
`ifdef FREELIST_ERR_EN
    logic               o_err;
`endif

    always #5 i_clk = ~i_clk;

    preg_freelist dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_req    (i_req),
        .o_ready  (o_ready),
        .o_addr4x (o_addr4x),
        .i_free4x (i_free4x),
        .o_count  (o_count),
        .o_empty  (o_empty)
`ifdef FREELIST_ERR_EN
        ,
        .o_err    (o_err)
`endif
    );

    typedef struct packed {
        logic           rdy;
        logic [4*W-1:0] addr;
        logic [W:0]     cnt;
        logic           emp;
        logic           err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: the free list is just a FIFO of register numbers;
    // outst holds registers currently handed out (candidates for release).
    int fl[$];
    int outst[$];
    bit merr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: one expectation per driven cycle, checked mid-cycle.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ready", 64'(o_ready), 64'(mon_e.rdy));
            chk("addr4x", 64'(o_addr4x), 64'(mon_e.addr));
            chk("count", 64'(o_count), 64'(mon_e.cnt));
            chk("empty", 64'(o_empty), 64'(mon_e.emp));
`ifdef FREELIST_ERR_EN
            chk("err", 64'(o_err), 64'(mon_e.err));
`endif
        end
    end

    task automatic model_reset();
        fl.delete();
        outst.delete();
        for (int i = 0; i < NR; i++) fl.push_back(ARCH_REGS + i);
        merr = 1'b0;
    endtask

    // Applies one cycle of stimulus; called just after a rising edge.
    task automatic drive(input logic v, input logic [3:0] r, input logic [4*W-1:0] f);
        exp_t e;
        int   sz0, pc, room, a;
        int   vals[$];
        sz0    = fl.size();
        pc     = $countones(r);
        e      = '0;
        e.cnt  = (W+1)'(sz0);
        e.emp  = (sz0 == 0);
        e.rdy  = (sz0 >= pc);
        e.err  = merr;
        if (v && e.rdy) begin
            for (int k = 0; k < 4; k++) begin
                if (r[k]) begin
                    a = fl.pop_front();
                    e.addr[k*W +: W] = W'(a);
                    outst.push_back(a);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (f[k*W +: W] != '0) vals.push_back(int'(f[k*W +: W]));
        end
        room = NR - sz0;
        for (int k = 0; k < vals.size() && k < room; k++) fl.push_back(vals[k]);
        if ((sz0 + vals.size() > NR) || (v && pc > sz0)) merr = 1'b1;
        i_valid  = v;
        i_req    = r;
        i_free4x = f;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic [3:0] r);
        i_rst    = 1'b1;
        i_valid  = v;
        i_req    = r;
        i_free4x = '0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    // Builds a release vector of up to n outstanding registers in random slots.
    task automatic make_free(input int n, output logic [4*W-1:0] f);
        int placed, idx;
        placed = 0;
        f      = '0;
        for (int k = 0; k < 4; k++) begin
            if (placed < n && outst.size() > 0 &&
                ($urandom_range(0, 1) == 1 || (4 - k) <= (n - placed))) begin
                idx = $urandom_range(0, outst.size() - 1);
                f[k*W +: W] = W'(outst[idx]);
                outst.delete(idx);
                placed++;
            end
        end
    endtask

    task automatic take_out(input int val);
        for (int i = 0; i < outst.size(); i++) begin
            if (outst[i] == val) begin
                outst.delete(i);
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [4*W-1:0] f;
        int             n;

        @(posedge i_clk);
        #1;
        do_reset(1'b0, 4'b0000);

        // Reset state and the first groups.
        drive(1'b0, 4'b0000, '0);
        drive(1'b1, 4'b1111, '0);
        drive(1'b1, 4'b0101, '0);

        // Drain to 2, then a group that does not fit, then one that does.
        for (int i = 0; i < 22; i++) drive(1'b1, 4'b1111, '0);
        drive(1'b1, 4'b0111, '0);
        drive(1'b1, 4'b0011, '0);
        drive(1'b0, 4'b0000, '0);
        drive(1'b1, 4'b0001, '0);   // empty list: not ready
        drive(1'b1, 4'b0000, '0);   // empty request always fires

        // Refill to 10 while keeping 40 and 50 aside.
        take_out(40);
        take_out(50);
        make_free(4, f); drive(1'b0, 4'b0000, f);
        make_free(4, f); drive(1'b0, 4'b0000, f);
        make_free(2, f); drive(1'b0, 4'b0000, f);
        f = '0;
        f[0*W +: W] = W'(40);
        f[1*W +: W] = W'(50);
        drive(1'b1, 4'b0001, f);
        for (int i = 0; i < 11; i++) drive(1'b1, 4'b0001, '0);
        drive(1'b0, 4'b0000, '0);

        // Steady alloc-1 / free-1 traffic; pointers wrap.
        make_free(4, f); drive(1'b0, 4'b0000, f);
        make_free(4, f); drive(1'b0, 4'b0000, f);
        for (int i = 0; i < 200; i++) begin
            make_free(1, f);
            drive(1'b1, 4'(1 << $urandom_range(0, 3)), f);
        end

        // Reset in the middle of a group.
        do_reset(1'b1, 4'b1111);
        drive(1'b1, 4'b1111, '0);

        // Release into a full list is dropped.
        do_reset(1'b0, 4'b0000);
        f = '0;
        f[0*W +: W] = W'(5);
        drive(1'b0, 4'b0000, f);
        drive(1'b0, 4'b0000, '0);
        do_reset(1'b0, 4'b0000);
        drive(1'b0, 4'b0000, '0);

        // Random mixed traffic.
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 4);
            make_free(n, f);
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), f);
        end
        drive(1'b0, 4'b0000, '0);

        @(posedge i_clk);
        #1;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
